cr16_mc_controller: RTL and testbench

- Parametrised multicycle control FSM for the 16-bit CR16-subset datapath.
- Replaces hand-driven datapath select lines with a sequencer: fetch, decode, execute, memory and writeback.
- Adds a memory ready/valid handshake with timeout, and condition-code evaluation for Bcond and Jcond.
- Sits beside the datapath. Consumes the instruction word and flags; drives every datapath select and enable.

---
 rtl/cr16_ctrl_pkg.sv | 77 +++++++
 rtl/cr16_mc_controller_if.sv | 34 +++
 rtl/cr16_cond_eval.sv | 34 +++
 rtl/cr16_mc_controller.sv | 161 ++++++++++++++++
 tb/tb_cr16_mc_controller.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/cr16_ctrl_pkg.sv
// Shared definitions for the CR16-subset multicycle controller: states,
// opcode/opext fields, datapath select codes and branch condition codes.
package cr16_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_RTYPE   = 4'd2,
    ST_ITYPE   = 4'd3,
    ST_LOAD    = 4'd4,
    ST_LOAD_WB = 4'd5,
    ST_STORE   = 4'd6,
    ST_BCOND   = 4'd7,
    ST_JCOND   = 4'd8,
    ST_JAL     = 4'd9,
    ST_ERR     = 4'd10
  } state_t;

  localparam logic [3:0] OP_RTYPE = 4'b0000;
  localparam logic [3:0] OP_ADDI  = 4'b0101;
  localparam logic [3:0] OP_MOVI  = 4'b1101;
  localparam logic [3:0] OP_MEM   = 4'b0100;
  localparam logic [3:0] OP_BCOND = 4'b1100;

  localparam logic [3:0] OPX_LOAD  = 4'b0000;
  localparam logic [3:0] OPX_STOR  = 4'b0100;
  localparam logic [3:0] OPX_JCOND = 4'b1100;
  localparam logic [3:0] OPX_JAL   = 4'b1000;
  localparam logic [3:0] OPX_MOV   = 4'b1101;

  localparam logic [1:0] ALUA_RDEST = 2'b00;
  localparam logic [1:0] ALUA_PC    = 2'b01;
  localparam logic [1:0] ALUA_ZERO  = 2'b10;

  localparam logic [1:0] WD_IMM = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC1 = 2'b10;
  localparam logic [1:0] WD_ALU = 2'b11;

  localparam logic PC_INC = 1'b0;
  localparam logic PC_TGT = 1'b1;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_GT = 4'b0110;
  localparam logic [3:0] COND_LE = 4'b0111;
  localparam logic [3:0] COND_FS = 4'b1000;
  localparam logic [3:0] COND_FC = 4'b1001;
  localparam logic [3:0] COND_UC = 4'b1110;

  // Instruction class selected in DECODE; unknown encodings land in ERR.
  function automatic state_t decode_op(input logic [3:0] opcode,
                                       input logic [3:0] opext,
                                       input logic       has_jal);
    state_t nxt;
    nxt = ST_ERR;
    case (opcode)
      OP_RTYPE:         nxt = ST_RTYPE;
      OP_ADDI, OP_MOVI: nxt = ST_ITYPE;
      OP_BCOND:         nxt = ST_BCOND;
      OP_MEM: begin
        case (opext)
          OPX_LOAD:  nxt = ST_LOAD;
          OPX_STOR:  nxt = ST_STORE;
          OPX_JCOND: nxt = ST_JCOND;
          OPX_JAL:   nxt = has_jal ? ST_JAL : ST_ERR;
          default:   nxt = ST_ERR;
        endcase
      end
      default:          nxt = ST_ERR;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/cr16_mc_controller_if.sv
// Controller <-> datapath/memory signal bundle; master is the controller side.
interface cr16_mc_controller_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] instr;
  logic [4:0]       flags;
  logic             mem_ready;
  logic             ir_en;
  logic             pcen;
  logic             pc_s;
  logic             wa_s;
  logic             alub_s;
  logic [1:0]       alua_s;
  logic [1:0]       wd_s;
  logic             mem_s;
  logic             signext_sign;
  logic             regwrite;
  logic             mem_req;
  logic             mem_we;
  logic             bus_err;
  logic [3:0]       state_o;

  modport master (
    input  instr, flags, mem_ready,
    output ir_en, pcen, pc_s, wa_s, alub_s, alua_s, wd_s, mem_s,
           signext_sign, regwrite, mem_req, mem_we, bus_err, state_o
  );

  modport slave (
    output instr, flags, mem_ready,
    input  ir_en, pcen, pc_s, wa_s, alub_s, alua_s, wd_s, mem_s,
           signext_sign, regwrite, mem_req, mem_we, bus_err, state_o
  );
endinterface

// File: rtl/cr16_cond_eval.sv
// Branch/jump condition evaluation from the PSR flags {Z,C,N,F,L}.
module cr16_cond_eval
  import cr16_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [4:0] flags,
  output logic       taken
);
  logic z, c, n, f;
  logic unused_l;

  assign z = flags[4];
  assign c = flags[3];
  assign n = flags[2];
  assign f = flags[1];
  // L is carried in the PSR but no supported condition uses it.
  assign unused_l = flags[0];

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_EQ: taken = z;
      COND_NE: taken = ~z;
      COND_CS: taken = c;
      COND_CC: taken = ~c;
      COND_GT: taken = n;
      COND_LE: taken = ~n;
      COND_FS: taken = f;
      COND_FC: taken = ~f;
      COND_UC: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end
endmodule

// File: rtl/cr16_mc_controller.sv
// Multicycle fetch/decode/execute/memory/writeback sequencer driving every
// datapath select and enable, with a bounded memory ready handshake.
module cr16_mc_controller
  import cr16_ctrl_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int MAX_WAIT = 15,
  parameter bit HAS_JAL  = 1'b1
) (
  input  logic                        clk,
  input  logic                        reset,
  cr16_mc_controller_if.master        bus
);
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [3:0]       opcode, cond, opext;
  logic             taken, timeout;
  logic             unused_instr;

  logic       ir_en, pcen, pc_s, wa_s, alub_s, mem_s, signext_sign;
  logic       regwrite, mem_req, mem_we, bus_err;
  logic [1:0] alua_s, wd_s;

  assign opcode = bus.instr[WIDTH-1  -: 4];
  assign cond   = bus.instr[WIDTH-5  -: 4];
  assign opext  = bus.instr[WIDTH-9  -: 4];
  assign unused_instr = ^bus.instr[WIDTH-13:0];

  cr16_cond_eval u_cond_eval (
    .cond  (cond),
    .flags (bus.flags),
    .taken (taken)
  );

  assign timeout = (wait_cnt_q == CNT_W'(MAX_WAIT)) && !bus.mem_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_FETCH;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Outputs are forced to their idle values while reset is held so an
  // in-flight memory request drops in the same cycle.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = '0;
    ir_en        = 1'b0;
    pcen         = 1'b0;
    pc_s         = PC_INC;
    wa_s         = 1'b0;
    alub_s       = 1'b0;
    alua_s       = ALUA_RDEST;
    wd_s         = WD_ALU;
    mem_s        = 1'b0;
    signext_sign = 1'b0;
    regwrite     = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    bus_err      = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_FETCH: begin
          mem_req = 1'b1;
          if (bus.mem_ready) begin
            ir_en   = 1'b1;
            pcen    = 1'b1;
            state_d = ST_DECODE;
          end else if (timeout) begin
            state_d = ST_ERR;
          end
        end
        ST_DECODE: state_d = decode_op(opcode, opext, HAS_JAL);
        ST_RTYPE: begin
          alua_s   = (opext == OPX_MOV) ? ALUA_ZERO : ALUA_RDEST;
          wa_s     = 1'b1;
          regwrite = 1'b1;
          state_d  = ST_FETCH;
        end
        ST_ITYPE: begin
          alub_s       = 1'b1;
          alua_s       = (opcode == OP_MOVI) ? ALUA_ZERO : ALUA_RDEST;
          signext_sign = (opcode != OP_MOVI);
          wa_s         = 1'b1;
          regwrite     = 1'b1;
          state_d      = ST_FETCH;
        end
        ST_LOAD: begin
          mem_req = 1'b1;
          mem_s   = 1'b1;
          if (bus.mem_ready) state_d = ST_LOAD_WB;
          else if (timeout)  state_d = ST_ERR;
        end
        ST_LOAD_WB: begin
          wd_s     = WD_MEM;
          wa_s     = 1'b1;
          regwrite = 1'b1;
          state_d  = ST_FETCH;
        end
        ST_STORE: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          mem_s   = 1'b1;
          if (bus.mem_ready) state_d = ST_FETCH;
          else if (timeout)  state_d = ST_ERR;
        end
        ST_BCOND: begin
          if (taken) begin
            alua_s       = ALUA_PC;
            alub_s       = 1'b1;
            signext_sign = 1'b1;
            pc_s         = PC_TGT;
            pcen         = 1'b1;
          end
          state_d = ST_FETCH;
        end
        ST_JCOND: begin
          if (taken) begin
            pc_s = PC_TGT;
            pcen = 1'b1;
          end
          state_d = ST_FETCH;
        end
        ST_JAL: begin
          wd_s     = WD_PC1;
          wa_s     = 1'b1;
          regwrite = 1'b1;
          pc_s     = PC_TGT;
          pcen     = 1'b1;
          state_d  = ST_FETCH;
        end
        ST_ERR:  bus_err = 1'b1;
        default: state_d = ST_ERR;
      endcase
      if (mem_req && !bus.mem_ready && !timeout)
        wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  assign bus.ir_en        = ir_en;
  assign bus.pcen         = pcen;
  assign bus.pc_s         = pc_s;
  assign bus.wa_s         = wa_s;
  assign bus.alub_s       = alub_s;
  assign bus.alua_s       = alua_s;
  assign bus.wd_s         = wd_s;
  assign bus.mem_s        = mem_s;
  assign bus.signext_sign = signext_sign;
  assign bus.regwrite     = regwrite;
  assign bus.mem_req      = mem_req;
  assign bus.mem_we       = mem_we;
  assign bus.bus_err      = bus_err;
  assign bus.state_o      = reset ? ST_FETCH : state_q;

endmodule

// File: tb/tb_cr16_mc_controller.sv
// Directed bench for cr16_mc_controller: walks each instruction class,
// the memory timeout, illegal opcode and reset-during-wait cases.
module tb_cr16_mc_controller;
  import cr16_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  cr16_mc_controller_if #(.WIDTH(16)) ifc ();

  cr16_mc_controller #(.WIDTH(16), .MAX_WAIT(15), .HAS_JAL(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  // {ir_en,pcen,pc_s,wa_s,alub_s,alua_s,wd_s,mem_s,signext,regwrite,mem_req,mem_we,bus_err}
  logic [14:0] obs;
  assign obs = {ifc.ir_en, ifc.pcen, ifc.pc_s, ifc.wa_s, ifc.alub_s, ifc.alua_s,
                ifc.wd_s, ifc.mem_s, ifc.signext_sign, ifc.regwrite, ifc.mem_req,
                ifc.mem_we, ifc.bus_err};

  function automatic logic [14:0] ov(input logic ir, pcen, pcs, wa, alub,
                                     input logic [1:0] alua, wd,
                                     input logic ms, sx, rw, req, we, err);
    return {ir, pcen, pcs, wa, alub, alua, wd, ms, sx, rw, req, we, err};
  endfunction

  logic [14:0] idle_o, fetch_wait_o, fetch_go_o;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] exp_st, input logic [14:0] exp_o);
    #1;
    n_checks++;
    assert (ifc.state_o === exp_st && obs === exp_o) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed state=%0d outs=%b expected state=%0d outs=%b",
             tag, ifc.state_o, obs, exp_st, exp_o);
    end
  endtask

  // Fetch with ready on the first cycle, then land in DECODE.
  task automatic fetch_decode(input logic [15:0] ins, input string tag);
    ifc.instr = ins;
    ifc.mem_ready = 1'b1;
    chk({tag, "_fetch"}, ST_FETCH, fetch_go_o);
    cycle();
    ifc.mem_ready = 1'b0;
    chk({tag, "_decode"}, ST_DECODE, idle_o);
    cycle();
  endtask

  initial begin
    idle_o       = ov(0,0,0,0,0,2'b00,2'b11,0,0,0,0,0,0);
    fetch_wait_o = ov(0,0,0,0,0,2'b00,2'b11,0,0,0,1,0,0);
    fetch_go_o   = ov(1,1,0,0,0,2'b00,2'b11,0,0,0,1,0,0);

    reset = 1'b1;
    ifc.instr = 16'h0000;
    ifc.flags = 5'b00000;
    ifc.mem_ready = 1'b0;
    cycle();
    cycle();
    chk("reset_hold", ST_FETCH, idle_o);
    reset = 1'b0;
    chk("fetch_wait", ST_FETCH, fetch_wait_o);

    // ADD: 3 cycles FETCH -> DECODE -> RTYPE
    fetch_decode(16'h0152, "add");
    chk("add_rtype", ST_RTYPE, ov(0,0,0,1,0,2'b00,2'b11,0,0,1,0,0,0));
    cycle();

    // LOAD with 3 wait cycles, then LOAD_WB
    ifc.instr = 16'h4203;
    chk("load_fetch_wait", ST_FETCH, fetch_wait_o);
    cycle();
    fetch_decode(16'h4203, "load");
    for (int i = 0; i < 3; i++) begin
      chk("load_wait", ST_LOAD, ov(0,0,0,0,0,2'b00,2'b11,1,0,0,1,0,0));
      cycle();
    end
    ifc.mem_ready = 1'b1;
    chk("load_ready", ST_LOAD, ov(0,0,0,0,0,2'b00,2'b11,1,0,0,1,0,0));
    cycle();
    ifc.mem_ready = 1'b0;
    chk("load_wb", ST_LOAD_WB, ov(0,0,0,1,0,2'b00,2'b01,0,0,1,0,0,0));
    cycle();

    // STORE
    fetch_decode(16'h4243, "store");
    ifc.mem_ready = 1'b1;
    chk("store", ST_STORE, ov(0,0,0,0,0,2'b00,2'b11,1,0,0,1,1,0));
    cycle();

    // ADDI
    fetch_decode(16'h5105, "addi");
    chk("addi_itype", ST_ITYPE, ov(0,0,0,1,1,2'b00,2'b11,0,1,1,0,0,0));
    cycle();

    // BCOND EQ taken with Z=1
    ifc.flags = 5'b10000;
    fetch_decode(16'hC0FE, "beq_t");
    chk("beq_taken", ST_BCOND, ov(0,1,1,0,1,2'b01,2'b11,0,1,0,0,0,0));
    cycle();
    // BCOND EQ not taken with Z=0
    ifc.flags = 5'b00000;
    fetch_decode(16'hC0FE, "beq_n");
    chk("beq_not_taken", ST_BCOND, idle_o);
    cycle();
    // cond 1111 never taken
    ifc.flags = 5'b11111;
    fetch_decode(16'hCFFE, "b1111");
    chk("bcond_1111", ST_BCOND, idle_o);
    cycle();

    // JCOND unconditional
    ifc.flags = 5'b00000;
    fetch_decode(16'h4EC3, "juc");
    chk("jcond_uc", ST_JCOND, ov(0,1,1,0,0,2'b00,2'b11,0,0,0,0,0,0));
    cycle();

    // JAL
    fetch_decode(16'h4E83, "jal");
    chk("jal", ST_JAL, ov(0,1,1,1,0,2'b00,2'b10,0,0,1,0,0,0));
    cycle();

    // Timeout: 16 FETCH cycles without ready, then ERR
    ifc.mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) cycle();
    chk("fetch_cycle16", ST_FETCH, fetch_wait_o);
    cycle();
    chk("timeout_err", ST_ERR, ov(0,0,0,0,0,2'b00,2'b11,0,0,0,0,0,1));
    ifc.mem_ready = 1'b1;
    cycle();
    cycle();
    chk("err_sticky", ST_ERR, ov(0,0,0,0,0,2'b00,2'b11,0,0,0,0,0,1));
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    ifc.mem_ready = 1'b0;
    chk("err_reset", ST_FETCH, fetch_wait_o);

    // Illegal opcode
    fetch_decode(16'hF000, "illegal");
    chk("illegal_err", ST_ERR, ov(0,0,0,0,0,2'b00,2'b11,0,0,0,0,0,1));
    reset = 1'b1;
    cycle();
    reset = 1'b0;

    // Reset during LOAD wait
    fetch_decode(16'h4203, "load2");
    chk("load2_wait", ST_LOAD, ov(0,0,0,0,0,2'b00,2'b11,1,0,0,1,0,0));
    reset = 1'b1;
    chk("reset_drops_req", ST_FETCH, idle_o);
    cycle();
    chk("reset_to_fetch", ST_FETCH, idle_o);
    reset = 1'b0;
    chk("after_reset_fetch", ST_FETCH, fetch_wait_o);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no completion expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
